mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port synchronous RAM (1-cycle read latency, byte write enables) between the CPU instruction-fetch requester (I, read-only) and the load/store requester (D, read/write). Sits between the Riscv151 fetch/memory stages and the BIOS/data memory. Issues at most one memory access per cycle. D has priority, with a starvation guard for I, and routes each read response back to its owner one cycle after acceptance.

Parameters:
ADDR_WIDTH, 14, word address width of the RAM
DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 wide
STARVE_LIMIT, 4, consecutive denied cycles of a valid I request before I is forced to win; must be >= 1

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
i_req_valid  input  1  I request present
i_req_ready  output  1  I request accepted this cycle
i_req_addr  input  ADDR_WIDTH  I word address
i_flush  input  1  discard in-flight I response; block I acceptance this cycle
i_resp_valid  output  1  I read data valid
i_resp_data  output  DATA_WIDTH  I read data
d_req_valid  input  1  D request present
d_req_ready  output  1  D request accepted this cycle
d_req_addr  input  ADDR_WIDTH  D word address
d_req_we  input  DATA_WIDTH/8  byte write enables; 0 = read
d_req_wdata  input  DATA_WIDTH  D write data
d_resp_valid  output  1  D response (read data, or write ack)
d_resp_data  output  DATA_WIDTH  D read data; 0 for write acks
mem_en  output  1  RAM enable
mem_we  output  DATA_WIDTH/8  RAM byte write enables
mem_addr  output  ADDR_WIDTH  RAM address
mem_din  output  DATA_WIDTH  RAM write data
mem_dout  input  DATA_WIDTH  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (async assert, sync release): starve_cnt=0, resp_owner=NONE, resp_is_write=0. All response valids 0. Request readys are 0 while rst is high.
- Grant (combinational, per cycle). Let iv = i_req_valid & ~i_flush and dv = d_req_valid.
  - Grant I if iv & (~dv | starve_cnt >= STARVE_LIMIT).
  - Else grant D if dv.
  - Else no grant.
- Handshake: X_req_ready = grant_X. A request is accepted when valid & ready. Requesters hold valid/addr/data stable until accepted. A ready may assert in the same cycle valid rises (zero-latency acceptance).
- Memory drive (same cycle as grant): mem_en=1; addr/we/din come from the winner. I always drives we=0. With no grant: mem_en=0, mem_we=0, and addr/din hold 0.
- starve_cnt:
  - Reset to 0 when I is granted or i_req_valid=0.
  - Otherwise, when i_req_valid=1 and I is not granted, increment, saturating at STARVE_LIMIT.
  - i_flush cycles with a pending I request also count as denials.
- Response tracking register, updated each cycle:
  - resp_owner <= I, D, or NONE according to the grant.
  - resp_is_write <= (D granted & |d_req_we).
- Response at cycle N+1 for acceptance at cycle N:
  - owner I: i_resp_valid = ~i_flush, i_resp_data = mem_dout.
  - owner D: d_resp_valid = 1; d_resp_data = resp_is_write ? 0 : mem_dout.
  - Non-owner resp_data is driven 0.
- Responses cannot be back-pressured; requesters must consume them in the cycle they appear.
- Throughput: one access per cycle, back-to-back. A new request can be accepted in the same cycle an earlier response is returned.
- Flush boundaries:
  - Flush in the response cycle suppresses that I response.
  - Flush in the request cycle blocks I acceptance, so D (if valid) wins.
  - A flush never affects D.
- Simultaneous valid I and D with starve_cnt < STARVE_LIMIT: D wins.
- Reset mid-transaction: a pending response is dropped and never emitted after reset is released.

Decomposition:
- Shared package mem_arb_pkg:
  - owner encoding OWNER_NONE=2'd0, OWNER_I=2'd1, OWNER_D=2'd2
  - default widths (ADDR_WIDTH, DATA_WIDTH)
- One natural sub-module, mem_arb_grant: purely combinational grant logic taking iv, dv, and starve_cnt>=STARVE_LIMIT, producing grant_i and grant_d.
- Counter, response register and muxing stay in the top.

Test Plan:
- Reset then idle → all readys, mem_en, and response valids are 0. Assert rst mid-read (D read accepted) → no d_resp_valid after release.
- RAM preloaded word 0x10=0xDEADBEEF; I reads 0x10 → i_req_ready same cycle, next cycle i_resp_valid=1, i_resp_data=0xDEADBEEF.
- D writes 0x20, we=4'b0011, wdata=0x12345678, over existing 0xAAAAAAAA → d_resp_valid with data 0. D then reads 0x20 → 0xAAAA5678.
- I and D valid together for 10 cycles, STARVE_LIMIT=4 → D granted cycles 0-3, I granted cycle 4, then D 5-8, I cycle 9; starve_cnt returns to 0 after each I grant.
- I read accepted at cycle N with i_flush=1 at N+1 → i_resp_valid stays 0. i_flush with I and D both valid → D granted, i_req_ready=0.
- Alternating I read / D read back-to-back for 8 cycles → 8 responses, each routed to the correct requester with the correct data, and no idle memory cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// response owner encoding, default widths and a counter-width helper.
package mem_arb_pkg;

  localparam int DEF_ADDR_WIDTH   = 14;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  // Bits needed to hold values 0..limit inclusive.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decision: D wins by default, I wins when D is idle
// or when I has been starved long enough.
module mem_arb_grant (
  input  logic iv,
  input  logic dv,
  input  logic starved,
  output logic grant_i,
  output logic grant_d
);

  assign grant_i = iv & (~dv | starved);
  assign grant_d = dv & ~grant_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (I) and
// load/store (D); one access per cycle, responses routed back one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic                    i_flush,
  output logic                    i_resp_valid,
  output logic [DATA_WIDTH-1:0]   i_resp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH/8-1:0] d_req_we,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   d_resp_data,
  output logic                    mem_en,
  output logic [DATA_WIDTH/8-1:0] mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Handshake: a request transfers in any cycle where valid & ready; ready is
  // combinational (zero-latency), requesters hold valid/payload until taken,
  // and responses have no ready -- they must be consumed when presented.

  logic [CNT_W-1:0] starve_cnt;
  owner_e           resp_owner;
  logic             resp_is_write;
  logic             iv;
  logic             dv;
  logic             grant_i;
  logic             grant_d;

  // Readys are held low during reset by masking the request qualifiers.
  assign iv = i_req_valid & ~i_flush & ~rst;
  assign dv = d_req_valid & ~rst;

  mem_arb_grant u_grant (
    .iv      (iv),
    .dv      (dv),
    .starved (starve_cnt >= LIMIT),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_d) begin
      mem_en   = 1'b1;
      mem_we   = d_req_we;
      mem_addr = d_req_addr;
      mem_din  = d_req_wdata;
    end else if (grant_i) begin
      mem_en   = 1'b1;
      mem_addr = i_req_addr;
    end
  end

  // A flushed cycle with I still pending counts as a denial.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i || !i_req_valid) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner    <= OWNER_NONE;
      resp_is_write <= 1'b0;
    end else begin
      resp_owner    <= grant_i ? OWNER_I : (grant_d ? OWNER_D : OWNER_NONE);
      resp_is_write <= grant_d & (|d_req_we);
    end
  end

  always_comb begin
    i_resp_valid = 1'b0;
    i_resp_data  = '0;
    d_resp_valid = 1'b0;
    d_resp_data  = '0;
    case (resp_owner)
      OWNER_I: begin
        i_resp_valid = ~i_flush;
        i_resp_data  = mem_dout;
      end
      OWNER_D: begin
        d_resp_valid = 1'b1;
        d_resp_data  = resp_is_write ? '0 : mem_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic checked against a cycle-level reference model and reference memory.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req_valid = 1'b0;
  logic          i_req_ready;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_flush = 1'b0;
  logic          i_resp_valid;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic [AW-1:0] d_req_addr = '0;
  logic [BW-1:0] d_req_we = '0;
  logic [DW-1:0] d_req_wdata = '0;
  logic          d_resp_valid;
  logic [DW-1:0] d_resp_data;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_flush(i_flush), .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  // Physical RAM seen by the DUT (read-before-write, 1-cycle latency).
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr];
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];   // expected response data, one entry per cycle
  int            owner_q[$]; // 0 none, 1 I, 2 D
  int            starve = 0;
  bit            i_acc = 0, d_acc = 0;
  logic          last_i_ready, last_d_ready, last_i_valid, last_d_valid, last_mem_en;
  logic [DW-1:0] last_i_data, last_d_data;
  int            n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: compare at negedge, advance model, return #1 after posedge.
  task automatic step();
    int            own;
    logic [DW-1:0] rdat;
    bit            iv, dv, gi, gd;
    logic [DW-1:0] exp_addr, exp_din, exp_we;
    @(negedge clk);
    if (rst) begin
      owner_q.delete();
      exp_q.delete();
    end
    own  = 0;
    rdat = '0;
    if (owner_q.size() > 0) begin
      own  = owner_q.pop_front();
      rdat = exp_q.pop_front();
    end
    iv = i_req_valid && !i_flush && !rst;
    dv = d_req_valid && !rst;
    gi = iv && (!dv || starve >= LIMIT);
    gd = dv && !gi;
    exp_addr = gi ? DW'(i_req_addr) : (gd ? DW'(d_req_addr) : '0);
    exp_din  = gd ? d_req_wdata : '0;
    exp_we   = gd ? DW'(d_req_we) : '0;

    check("i_req_ready", i_req_ready, gi);
    check("d_req_ready", d_req_ready, gd);
    check("mem_en", mem_en, gi || gd);
    check("mem_we", mem_we, exp_we);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_din", mem_din, exp_din);
    check("i_resp_valid", i_resp_valid, (own == 1) && !i_flush);
    check("i_resp_data", i_resp_data, (own == 1) ? rdat : '0);
    check("d_resp_valid", d_resp_valid, own == 2);
    check("d_resp_data", d_resp_data, (own == 2) ? rdat : '0);

    last_i_ready = i_req_ready;  last_d_ready = d_req_ready;
    last_i_valid = i_resp_valid; last_d_valid = d_resp_valid;
    last_i_data  = i_resp_data;  last_d_data  = d_resp_data;
    last_mem_en  = mem_en;

    if (gi) begin
      owner_q.push_back(1);
      exp_q.push_back(ref_mem[i_req_addr]);
    end else if (gd) begin
      owner_q.push_back(2);
      if (d_req_we != '0) begin
        exp_q.push_back('0);
        for (int b = 0; b < BW; b++)
          if (d_req_we[b]) ref_mem[d_req_addr][b*8 +: 8] = d_req_wdata[b*8 +: 8];
      end else begin
        exp_q.push_back(ref_mem[d_req_addr]);
      end
    end else begin
      owner_q.push_back(0);
      exp_q.push_back('0);
    end

    if (rst || gi || !i_req_valid) starve = 0;
    else if (starve < LIMIT) starve++;
    i_acc = gi;
    d_acc = gd;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    i_req_valid = 1'b0; i_flush = 1'b0;
    d_req_valid = 1'b0; d_req_we = '0; d_req_wdata = '0;
  endtask

  task automatic drive_i(input logic [AW-1:0] a);
    i_req_valid = 1'b1; i_req_addr = a;
  endtask

  task automatic drive_d(input logic [AW-1:0] a, input logic [BW-1:0] we, input logic [DW-1:0] wd);
    d_req_valid = 1'b1; d_req_addr = a; d_req_we = we; d_req_wdata = wd;
  endtask

  // ---------------- stimulus ----------------
  bit exp_i_tab [10];
  int resp_cnt, en_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < (1 << AW); k++) begin
      ram[k] = '0;
      ref_mem[k] = '0;
    end
    ram[14'h10] = 32'hDEADBEEF; ref_mem[14'h10] = 32'hDEADBEEF;
    ram[14'h20] = 32'hAAAAAAAA; ref_mem[14'h20] = 32'hAAAAAAAA;
    for (int k = 0; k < 32; k++) begin
      ram[14'h40 + k] = 32'h1000_0000 + k;
      ref_mem[14'h40 + k] = 32'h1000_0000 + k;
    end

    // Reset with requests present: readys and memory stay quiet.
    #2;
    drive_i(14'h1); drive_d(14'h2, '0, '0);
    step(); step();
    check("rst_i_ready", last_i_ready, 1'b0);
    check("rst_d_ready", last_d_ready, 1'b0);
    drive_idle();
    rst = 1'b0;
    step();
    check("idle_mem_en", last_mem_en, 1'b0);

    // Instruction fetch of preloaded word.
    drive_i(14'h10);
    step();
    check("fetch_ready", last_i_ready, 1'b1);
    drive_idle();
    step();
    check("fetch_valid", last_i_valid, 1'b1);
    check("fetch_data", last_i_data, 32'hDEADBEEF);

    // Partial byte write then read back.
    drive_d(14'h20, 4'b0011, 32'h12345678);
    step();
    drive_idle();
    step();
    check("wr_ack_valid", last_d_valid, 1'b1);
    check("wr_ack_data", last_d_data, 32'h0);
    drive_d(14'h20, 4'b0000, 32'h0);
    step();
    drive_idle();
    step();
    check("rd_merge_data", last_d_data, 32'hAAAA5678);

    // Starvation guard: both valid for 10 cycles.
    for (int k = 0; k < 10; k++) exp_i_tab[k] = (k == 4) || (k == 9);
    for (int k = 0; k < 10; k++) begin
      drive_i(AW'(14'h40 + k));
      drive_d(AW'(14'h50 + k), '0, '0);
      step();
      check("starve_i_grant", last_i_ready, exp_i_tab[k]);
      check("starve_d_grant", last_d_ready, !exp_i_tab[k]);
    end
    drive_idle();
    step();

    // Flush in response cycle, then flush with both requesters valid.
    drive_i(14'h10);
    step();
    drive_idle();
    i_flush = 1'b1;
    step();
    check("flush_resp_valid", last_i_valid, 1'b0);
    drive_i(14'h41); drive_d(14'h42, '0, '0);
    step();
    check("flush_i_ready", last_i_ready, 1'b0);
    check("flush_d_ready", last_d_ready, 1'b1);
    drive_idle();
    step();

    // Alternating I / D reads back-to-back.
    resp_cnt = 0;
    en_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      drive_idle();
      if (k < 8) begin
        if (k % 2 == 0) drive_i(AW'(14'h40 + k));
        else drive_d(AW'(14'h48 + k), '0, '0);
      end
      step();
      resp_cnt += int'(last_i_valid) + int'(last_d_valid);
      if (k < 8) en_cnt += int'(last_mem_en);
    end
    check("alt_resp_count", resp_cnt, 8);
    check("alt_busy_cycles", en_cnt, 8);

    // Reset while a D read response is pending.
    drive_d(14'h10, '0, '0);
    step();
    drive_idle();
    rst = 1'b1;
    step();
    check("rst_mid_d_valid", last_d_valid, 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_d_valid", last_d_valid, 1'b0);

    // Random traffic; requesters hold their request until it is accepted.
    i_acc = 1; d_acc = 1;
    for (int c = 0; c < 500; c++) begin
      if (!i_req_valid || i_acc) begin
        i_req_valid = ($urandom_range(0, 3) != 0);
        i_req_addr  = AW'($urandom_range(14'h40, 14'h5F));
      end
      if (!d_req_valid || d_acc) begin
        d_req_valid = ($urandom_range(0, 2) != 0);
        d_req_addr  = AW'($urandom_range(14'h40, 14'h5F));
        d_req_we    = ($urandom_range(0, 1) != 0) ? BW'($urandom_range(1, 15)) : '0;
        d_req_wdata = $urandom;
      end
      i_flush = ($urandom_range(0, 7) == 0);
      step();
    end
    drive_idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
